wb_select_pipe: RTL and testbench
=================================

Name: wb_select_pipe

Overview:
Parametrised, registered successor to the register-file writeback multiplexer. It selects one of NUM_SRC data sources, or a constant reset-stack value, according to a writeback selector. The chosen word is registered together with its destination register and write-enable. Input and output use a valid/ready handshake with a 2-entry skid buffer, so the writeback path can stall without losing a beat; flush support and illegal-selector accounting are included.

Parameters:
DATA_W, 32, width of every data source and of out_data
NUM_SRC, 9, number of data sources; selector codes 1..NUM_SRC map to them
SEL_W, 4, selector width; must satisfy 2^SEL_W > NUM_SRC
CONST_VAL, 227, value produced for selector code 0 (initial stack pointer)
ERR_W, 8, width of the illegal-selector counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous; discards all buffered beats
in_valid  input  1  upstream beat present
in_ready  output  1  block can accept a beat this cycle
sel  input  SEL_W  writeback source selector
data_bus  input  NUM_SRC*DATA_W  packed sources; source k (1-based) occupies bits [k*DATA_W-1:(k-1)*DATA_W]
in_dest  input  5  destination register index
in_wr  input  1  register-write enable for this beat
out_valid  output  1  registered beat present
out_ready  input  1  downstream (register file) accepts the beat
out_data  output  DATA_W  selected word
out_dest  output  5  destination register index
out_wr  output  1  register-write enable
illegal_sel  output  1  one-cycle pulse, registered, when an accepted beat had an out-of-range selector
err_count  output  ERR_W  saturating count of accepted illegal-selector beats

Behaviour:
- Selection (combinational, before capture): sel==0 -> CONST_VAL zero-extended or truncated to DATA_W; 1<=sel<=NUM_SRC -> source sel; sel>NUM_SRC -> all zeros and the beat is flagged illegal.
- Accept: in_valid && in_ready && !flush. The payload {data, in_dest, in_wr} is captured.
- Storage: main register M (drives the outputs) and skid register S. State encoding: EMPTY, ONE (M full), TWO (M and S full).
- in_ready = (state != TWO). It is a decode of registered state only; there is no combinational path from out_ready.
- Pop: out_valid && out_ready.
- Transitions:
  - EMPTY + accept -> ONE. Latency is 1 cycle: the beat is visible on the outputs in the cycle after acceptance.
  - ONE + accept + pop -> ONE; M is loaded with the new beat.
  - ONE + accept, no pop -> TWO; the new beat goes to S.
  - ONE + pop, no accept -> EMPTY.
  - TWO + pop -> ONE; M is loaded from S. No accept is possible in TWO.
  - All other combinations hold the current state.
- Ordering: strict FIFO; beats are never reordered or duplicated.
- Stability: while out_valid && !out_ready, out_data, out_dest and out_wr hold constant.
- out_valid = (state != EMPTY).
- flush: the next state is EMPTY and both entries are invalidated. A beat presented in the same cycle is discarded, and illegal_sel and err_count do not update for it. The flush itself does not count as a pop.
- reset (dominates flush): state EMPTY, out_valid 0, out_data 0, out_dest 0, out_wr 0, illegal_sel 0, err_count 0. in_ready reads 1 on the first cycle after reset is released. Reset mid-stall drops all buffered beats.
- illegal_sel: asserted in the cycle after an illegal beat is accepted; 0 otherwise.
- err_count: increments by 1 per accepted illegal beat and saturates at 2^ERR_W-1, with no wrap-around.
- Width rules: the data slice index uses sel-1 and is evaluated only when sel is in range. No sign extension anywhere.

Test Plan:
1. Reset, then one beat with sel=0, in_dest=29, in_wr=1 -> next cycle out_valid=1, out_data=227, out_dest=29, out_wr=1; after out_ready, out_valid=0.
2. Sources k loaded with 0x1000_0000+k; streaming beats with sel=1..9 and out_ready held at 1 -> out_data sequence 0x10000001..0x10000009, one per cycle, latency 1, in_ready never low.
3. out_ready=0, push beats with sel=3 then sel=5 -> state TWO, in_ready=0, out_data holds 0x10000003. Then out_ready=1 -> 0x10000003, 0x10000005 in order, and in_ready=1 after the first pop.
4. sel=12 accepted -> out_data=0, illegal_sel pulses for 1 cycle, err_count=1. 300 illegal beats with ERR_W=8 -> err_count stops at 255.
5. State TWO with flush=1 and in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1, err_count unchanged. Reset asserted with flush -> all outputs 0.

Source files
------------

// File: rtl/wb_select_pipe_if.sv
// Writeback selector handshake bundle: upstream beat request plus the registered writeback beat.
interface wb_select_pipe_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_SRC = 9,
    parameter int unsigned SEL_W   = 4,
    parameter int unsigned ERR_W   = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic [SEL_W-1:0]          sel;
    logic [NUM_SRC*DATA_W-1:0] data_bus;
    logic [4:0]                in_dest;
    logic                      in_wr;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W-1:0]         out_data;
    logic [4:0]                out_dest;
    logic                      out_wr;
    logic                      illegal_sel;
    logic [ERR_W-1:0]          err_count;

    modport master (
        output in_valid, sel, data_bus, in_dest, in_wr, out_ready,
        input  in_ready, out_valid, out_data, out_dest, out_wr, illegal_sel, err_count
    );

    modport slave (
        input  in_valid, sel, data_bus, in_dest, in_wr, out_ready,
        output in_ready, out_valid, out_data, out_dest, out_wr, illegal_sel, err_count
    );
endinterface

// File: rtl/wb_select_pipe.sv
// Registered writeback source selector with a 2-entry skid buffer, flush and
// saturating illegal-selector accounting.
module wb_select_pipe #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_SRC   = 9,
    parameter int unsigned SEL_W     = 4,
    parameter int unsigned CONST_VAL = 227,
    parameter int unsigned ERR_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    wb_select_pipe_if.slave   bus
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [4:0]        dest;
        logic              wr;
    } beat_t;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t            state_q, state_d;
    beat_t             m_q, s_q;
    beat_t             in_beat;
    logic [DATA_W-1:0] sel_data;
    logic              sel_illegal;
    logic              accept, pop;
    logic              load_m_in, load_m_s, load_s;
    logic              in_ready_q, out_valid_q, illegal_q;
    logic [ERR_W-1:0]  err_q;

    // Source selection; slices are only addressed by in-range codes.
    always_comb begin
        sel_data    = '0;
        sel_illegal = bus.sel > SEL_W'(NUM_SRC);
        if (bus.sel == '0) begin
            sel_data = DATA_W'(CONST_VAL);
        end
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            if (bus.sel == SEL_W'(k)) begin
                sel_data = bus.data_bus[(k-1)*DATA_W +: DATA_W];
            end
        end
        in_beat = '{data: sel_data, dest: bus.in_dest, wr: bus.in_wr};
    end

    // Skid buffer next-state and load decode.
    always_comb begin
        state_d   = state_q;
        load_m_in = 1'b0;
        load_m_s  = 1'b0;
        load_s    = 1'b0;
        accept    = bus.in_valid && in_ready_q && !flush;
        pop       = out_valid_q && bus.out_ready;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d   = ONE;
                    load_m_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    load_m_in = 1'b1;
                end else if (accept) begin
                    state_d = TWO;
                    load_s  = 1'b1;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_d  = ONE;
                    load_m_s = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            m_q         <= '0;
            s_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != TWO);
            out_valid_q <= (state_d != EMPTY);
            illegal_q   <= accept && sel_illegal;
            if (load_m_in) begin
                m_q <= in_beat;
            end else if (load_m_s) begin
                m_q <= s_q;
            end
            if (load_s) begin
                s_q <= in_beat;
            end
            if (accept && sel_illegal && (err_q != '1)) begin
                err_q <= err_q + ERR_W'(1);
            end
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = m_q.data;
    assign bus.out_dest    = m_q.dest;
    assign bus.out_wr      = m_q.wr;
    assign bus.illegal_sel = illegal_q;
    assign bus.err_count   = err_q;

endmodule

// File: tb/tb_wb_select_pipe.sv
// Directed bench for wb_select_pipe: selection, latency, stall/skid ordering,
// illegal-selector saturation, flush and reset.
module tb_wb_select_pipe;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned NUM_SRC = 9;
    localparam int unsigned SEL_W   = 4;
    localparam int unsigned ERR_W   = 8;

    logic clk;
    logic reset;
    logic flush;
    int   checks;
    int   errors;

    wb_select_pipe_if #(
        .DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .ERR_W(ERR_W)
    ) bus ();

    wb_select_pipe #(
        .DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .CONST_VAL(227), .ERR_W(ERR_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [SEL_W-1:0] s, input logic [4:0] d, input logic w);
        bus.in_valid = v;
        bus.sel      = s;
        bus.in_dest  = d;
        bus.in_wr    = w;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        flush         = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            bus.data_bus[k*DATA_W +: DATA_W] = 32'h1000_0000 + 32'(k + 1);
        end
        step();
        step();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_err_count", 32'(bus.err_count), 32'd0);
        reset = 1'b0;
        step();
        check("rel_in_ready", 32'(bus.in_ready), 32'd1);

        // Constant source, latency 1
        drive(1'b1, 4'd0, 5'd29, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b0);
        check("const_valid", 32'(bus.out_valid), 32'd1);
        check("const_data", bus.out_data, 32'd227);
        check("const_dest", 32'(bus.out_dest), 32'd29);
        check("const_wr", 32'(bus.out_wr), 32'd1);
        bus.out_ready = 1'b1;
        step();
        check("const_popped", 32'(bus.out_valid), 32'd0);

        // Streaming every source with out_ready held high
        for (int k = 1; k <= int'(NUM_SRC); k++) begin
            drive(1'b1, SEL_W'(k), 5'(k), 1'(k));
            check("stream_in_ready", 32'(bus.in_ready), 32'd1);
            step();
            check("stream_valid", 32'(bus.out_valid), 32'd1);
            check("stream_data", bus.out_data, 32'h1000_0000 + 32'(k));
            check("stream_dest", 32'(bus.out_dest), 32'(k));
            check("stream_wr", 32'(bus.out_wr), 32'(k % 2));
        end
        drive(1'b0, '0, '0, 1'b0);
        step();
        check("stream_drained", 32'(bus.out_valid), 32'd0);

        // Stall into the skid entry, then drain in order
        bus.out_ready = 1'b0;
        drive(1'b1, 4'd3, 5'd3, 1'b1);
        step();
        drive(1'b1, 4'd5, 5'd5, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0);
        check("two_in_ready", 32'(bus.in_ready), 32'd0);
        check("two_data", bus.out_data, 32'h1000_0003);
        step();
        check("stall_hold_data", bus.out_data, 32'h1000_0003);
        check("stall_hold_dest", 32'(bus.out_dest), 32'd3);
        bus.out_ready = 1'b1;
        step();
        check("skid_second_data", bus.out_data, 32'h1000_0005);
        check("skid_second_wr", 32'(bus.out_wr), 32'd0);
        check("skid_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        check("skid_drained", 32'(bus.out_valid), 32'd0);

        // Illegal selector and saturation
        drive(1'b1, 4'd12, 5'd1, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b0);
        check("illegal_data", bus.out_data, 32'd0);
        check("illegal_pulse", 32'(bus.illegal_sel), 32'd1);
        check("illegal_count1", 32'(bus.err_count), 32'd1);
        step();
        check("illegal_pulse_end", 32'(bus.illegal_sel), 32'd0);
        check("illegal_count_hold", 32'(bus.err_count), 32'd1);
        drive(1'b1, 4'd15, 5'd0, 1'b0);
        repeat (253) step();
        check("sat_count254", 32'(bus.err_count), 32'd254);
        step();
        check("sat_count255", 32'(bus.err_count), 32'd255);
        repeat (46) step();
        check("sat_no_wrap", 32'(bus.err_count), 32'd255);
        drive(1'b0, '0, '0, 1'b0);
        step();
        check("sat_pulse_end", 32'(bus.illegal_sel), 32'd0);
        step();

        // Reset together with flush while stalled in TWO
        bus.out_ready = 1'b0;
        drive(1'b1, 4'd7, 5'd7, 1'b1);
        step();
        step();
        check("pre_reset_two", 32'(bus.in_ready), 32'd0);
        drive(1'b0, '0, '0, 1'b0);
        reset = 1'b1;
        flush = 1'b1;
        step();
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_data", bus.out_data, 32'd0);
        check("midrst_dest", 32'(bus.out_dest), 32'd0);
        check("midrst_wr", 32'(bus.out_wr), 32'd0);
        check("midrst_err", 32'(bus.err_count), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        reset = 1'b0;
        flush = 1'b0;
        step();

        // Flush in TWO with a beat presented
        drive(1'b1, 4'd1, 5'd1, 1'b1);
        step();
        drive(1'b1, 4'd2, 5'd2, 1'b1);
        step();
        check("flush_pre_two", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 4'd13, 5'd9, 1'b1);
        flush = 1'b1;
        step();
        check("flush_two_valid", 32'(bus.out_valid), 32'd0);
        check("flush_two_ready", 32'(bus.in_ready), 32'd1);
        check("flush_two_err", 32'(bus.err_count), 32'd0);

        // Flush in ONE drops an otherwise acceptable illegal beat
        flush = 1'b0;
        drive(1'b1, 4'd4, 5'd4, 1'b1);
        step();
        drive(1'b1, 4'd14, 5'd9, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        check("flush_one_valid", 32'(bus.out_valid), 32'd0);
        check("flush_one_err", 32'(bus.err_count), 32'd0);
        check("flush_one_pulse", 32'(bus.illegal_sel), 32'd0);
        bus.out_ready = 1'b1;
        step();
        check("flush_no_stale", 32'(bus.out_valid), 32'd0);
        drive(1'b1, 4'd6, 5'd6, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0);
        check("post_flush_data", bus.out_data, 32'h1000_0006);
        check("post_flush_dest", 32'(bus.out_dest), 32'd6);
        step();
        check("post_flush_drain", 32'(bus.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
